// File: rtl/uart_host_if.sv
// AXI-stream style word bundle used for both directions of uart_host.
// Master drives tdata/tvalid, slave answers with tready.
interface uart_host_if #(
    parameter int DATA_WIDTH_BYTES = 1
);
    logic [8*DATA_WIDTH_BYTES-1:0] tdata;
    logic                          tvalid;
    logic                          tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_host.sv
// Full-duplex 8N1 UART bridging multi-byte stream words to a serial line.
// Words go out and come in most-significant byte first.
module uart_host #(
    parameter int INP_BYTES = 1,
    parameter int OUT_BYTES = 1
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic [15:0] prescale,
    uart_host_if.slave  s_axis,
    uart_host_if.master m_axis,
    output logic        txd,
    input  logic        rxd,
    output logic        tx_busy,
    output logic        rx_busy,
    output logic        rx_error
);
    localparam int IW = 8 * INP_BYTES;
    localparam int OW = 8 * OUT_BYTES;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [15:0] ps_eff;
    logic [18:0] per_now;
    logic [18:0] half_now;

    assign ps_eff   = (prescale == 16'd0) ? 16'd1 : prescale;
    assign per_now  = {ps_eff, 3'b000};
    assign half_now = {1'b0, ps_eff, 2'b00};

    logic [1:0]    tx_st_q, tx_st_d;
    logic [18:0]   tx_cnt_q, tx_cnt_d;
    logic [18:0]   tx_per_q, tx_per_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic [IW-1:0] tx_word_q, tx_word_d;
    logic [7:0]    tx_left_q, tx_left_d;
    logic          txd_q, txd_d;

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_cnt_d  = tx_cnt_q;
        tx_per_d  = tx_per_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_word_d = tx_word_q;
        tx_left_d = tx_left_q;
        txd_d     = txd_q;
        if (tx_st_q != S_IDLE) tx_cnt_d = tx_cnt_q - 19'd1;
        unique case (tx_st_q)
            S_IDLE: begin
                if (s_axis.tvalid) begin
                    tx_st_d   = S_START;
                    tx_cnt_d  = per_now - 19'd1;
                    tx_per_d  = per_now;
                    tx_sh_d   = s_axis.tdata[IW-1 -: 8];
                    tx_word_d = s_axis.tdata << 8;
                    tx_left_d = 8'(INP_BYTES - 1);
                    txd_d     = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt_q == 19'd0) begin
                    tx_st_d  = S_DATA;
                    tx_cnt_d = tx_per_q - 19'd1;
                    tx_bit_d = 3'd0;
                    txd_d    = tx_sh_q[0];
                end
            end
            S_DATA: begin
                if (tx_cnt_q == 19'd0) begin
                    tx_cnt_d = tx_per_q - 19'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_st_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = tx_sh_q >> 1;
                        txd_d    = tx_sh_q[1];
                    end
                end
            end
            S_STOP: begin
                if (tx_cnt_q == 19'd0) begin
                    // Next byte of the word starts with no idle gap
                    if (tx_left_q != 8'd0) begin
                        tx_st_d   = S_START;
                        tx_cnt_d  = per_now - 19'd1;
                        tx_per_d  = per_now;
                        tx_sh_d   = tx_word_q[IW-1 -: 8];
                        tx_word_d = tx_word_q << 8;
                        tx_left_d = tx_left_q - 8'd1;
                        txd_d     = 1'b0;
                    end else begin
                        tx_st_d = S_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            tx_st_q   <= S_IDLE;
            tx_cnt_q  <= '0;
            tx_per_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            tx_word_q <= '0;
            tx_left_q <= '0;
            txd_q     <= 1'b1;
        end else begin
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_per_q  <= tx_per_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            tx_word_q <= tx_word_d;
            tx_left_q <= tx_left_d;
            txd_q     <= txd_d;
        end
    end

    assign s_axis.tready = (tx_st_q == S_IDLE);
    assign tx_busy       = (tx_st_q != S_IDLE);
    assign txd           = txd_q;

    logic          sync1_q, sync2_q, prev_q;
    logic [1:0]    rx_st_q, rx_st_d;
    logic [18:0]   rx_cnt_q, rx_cnt_d;
    logic [18:0]   rx_per_q, rx_per_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [OW-1:0] rx_word_q, rx_word_d;
    logic [7:0]    rx_nb_q, rx_nb_d;
    logic [OW-1:0] m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          err_q, err_d;
    logic [OW-1:0] rx_next;
    logic          complete;

    assign rx_next = (rx_word_q << 8) | OW'(rx_sh_q);

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_cnt_d  = rx_cnt_q;
        rx_per_d  = rx_per_q;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_word_d = rx_word_q;
        rx_nb_d   = rx_nb_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        err_d     = err_q;
        complete  = 1'b0;
        if (m_valid_q && m_axis.tready) m_valid_d = 1'b0;
        if (rx_st_q != S_IDLE) rx_cnt_d = rx_cnt_q - 19'd1;
        unique case (rx_st_q)
            S_IDLE: begin
                if (prev_q && !sync2_q) begin
                    rx_st_d  = S_START;
                    rx_cnt_d = half_now - 19'd1;
                    rx_per_d = per_now;
                end
            end
            S_START: begin
                if (rx_cnt_q == 19'd0) begin
                    if (sync2_q) begin
                        rx_st_d = S_IDLE;
                    end else begin
                        rx_st_d  = S_DATA;
                        rx_cnt_d = rx_per_q - 19'd1;
                        rx_bit_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (rx_cnt_q == 19'd0) begin
                    rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
                    rx_cnt_d = rx_per_q - 19'd1;
                    if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
                    else rx_bit_d = rx_bit_q + 3'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == 19'd0) begin
                    rx_st_d = S_IDLE;
                    if (!sync2_q) begin
                        err_d = 1'b1;
                    end else if (rx_nb_q == 8'(OUT_BYTES - 1)) begin
                        complete = 1'b1;
                        rx_nb_d  = 8'd0;
                    end else begin
                        rx_word_d = rx_next;
                        rx_nb_d   = rx_nb_q + 8'd1;
                    end
                end
            end
        endcase
        // A held word that is not being taken wins over the new one
        if (complete) begin
            if (m_valid_q && !m_axis.tready) begin
                err_d = 1'b1;
            end else begin
                m_data_d  = rx_next;
                m_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_per_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_word_q <= '0;
            rx_nb_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync1_q   <= rxd;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_per_q  <= rx_per_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_word_q <= rx_word_d;
            rx_nb_q   <= rx_nb_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
        end
    end

    assign m_axis.tdata  = m_data_q;
    assign m_axis.tvalid = m_valid_q;
    assign rx_busy       = (rx_st_q != S_IDLE);
    assign rx_error      = err_q;
endmodule

// File: tb/tb_uart_host.sv
// Directed bench for uart_host: a 2-byte instance for TX/loopback/reset
// and a 1-byte instance driven serially for framing, overrun and glitches.
module tb_uart_host;
    logic        clk = 1'b0;
    logic        arstn;
    logic [15:0] prescale;

    always #5 clk = ~clk;

    uart_host_if #(.DATA_WIDTH_BYTES(2)) a_s ();
    uart_host_if #(.DATA_WIDTH_BYTES(2)) a_m ();
    uart_host_if #(.DATA_WIDTH_BYTES(1)) b_s ();
    uart_host_if #(.DATA_WIDTH_BYTES(1)) b_m ();

    logic a_txd, a_rxd, a_txb, a_rxb, a_err;
    logic b_txd, b_rxd, b_txb, b_rxb, b_err;
    logic loop, a_drv;

    assign a_rxd = loop ? a_txd : a_drv;

    uart_host #(.INP_BYTES(2), .OUT_BYTES(2)) u_a (
        .clk      (clk),
        .arstn    (arstn),
        .prescale (prescale),
        .s_axis   (a_s),
        .m_axis   (a_m),
        .txd      (a_txd),
        .rxd      (a_rxd),
        .tx_busy  (a_txb),
        .rx_busy  (a_rxb),
        .rx_error (a_err)
    );

    uart_host #(.INP_BYTES(1), .OUT_BYTES(1)) u_b (
        .clk      (clk),
        .arstn    (arstn),
        .prescale (prescale),
        .s_axis   (b_s),
        .m_axis   (b_m),
        .txd      (b_txd),
        .rxd      (b_rxd),
        .tx_busy  (b_txb),
        .rx_busy  (b_rxb),
        .rx_error (b_err)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] qa[$];
    logic [7:0]  qb[$];

    always @(posedge clk) begin
        if (a_m.tvalid && a_m.tready) qa.push_back(a_m.tdata);
        if (b_m.tvalid && b_m.tready) qb.push_back(b_m.tdata);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        arstn = 1'b0;
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_a(input logic [15:0] w, input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (!a_s.tready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_rdy"}, a_s.tready, 1);
        a_s.tdata  = w;
        a_s.tvalid = 1'b1;
        @(posedge clk);
        #1 a_s.tvalid = 1'b0;
    endtask

    // Samples each 16-cycle bit at its first and last cycle
    task automatic tx_check(input logic [15:0] w, input logic [19:0] exp,
                            input string tag);
        logic [19:0] ca, cb;
        int busy;
        ca = '0;
        cb = '0;
        busy = 0;
        send_a(w, tag);
        for (int k = 0; k < 320; k++) begin
            @(negedge clk);
            if (k % 16 == 0) ca[k/16] = a_txd;
            if (k % 16 == 15) cb[k/16] = a_txd;
            if (a_txb) busy++;
        end
        @(negedge clk);
        chk({tag, "_bits_early"}, 32'(ca), 32'(exp));
        chk({tag, "_bits_late"}, 32'(cb), 32'(exp));
        chk({tag, "_busy_cycles"}, busy, 320);
        chk({tag, "_busy_end"}, a_txb, 0);
        chk({tag, "_ready_end"}, a_s.tready, 1);
        chk({tag, "_txd_idle"}, a_txd, 1);
    endtask

    task automatic ser_b(input logic [7:0] d, input logic stopb);
        logic [9:0] fr;
        fr = {stopb, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            b_rxd = fr[i];
            repeat (16) @(negedge clk);
        end
        b_rxd = 1'b1;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        arstn      = 1'b0;
        prescale   = 16'd2;
        loop       = 1'b0;
        a_drv      = 1'b1;
        b_rxd      = 1'b1;
        a_s.tvalid = 1'b0;
        a_s.tdata  = '0;
        a_m.tready = 1'b0;
        b_s.tvalid = 1'b0;
        b_s.tdata  = '0;
        b_m.tready = 1'b0;

        @(negedge clk);
        chk("rst_txd", a_txd, 1);
        chk("rst_tx_busy", a_txb, 0);
        chk("rst_rx_busy", a_rxb, 0);
        chk("rst_rx_error", a_err, 0);
        chk("rst_m_tvalid", a_m.tvalid, 0);
        chk("rst_s_tready", a_s.tready, 1);
        chk("rst_b_txd", b_txd, 1);
        chk("rst_b_tx_busy", b_txb, 0);
        chk("rst_b_m_tvalid", b_m.tvalid, 0);
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);

        // A5 then 5A, each framed 0-data-1, LSB first
        tx_check(16'hA55A, 20'hAD34A, "tx_a55a");

        loop = 1'b1;
        a_m.tready = 1'b1;
        qa.delete();
        send_a(16'h1234, "lb0");
        send_a(16'hFFFF, "lb1");
        send_a(16'h0000, "lb2");
        for (int t = 0; t < 2000 && qa.size() < 3; t++) @(negedge clk);
        repeat (40) @(negedge clk);
        chk("lb_count", qa.size(), 3);
        if (qa.size() == 3) begin
            chk("lb_word0", qa[0], 16'h1234);
            chk("lb_word1", qa[1], 16'hFFFF);
            chk("lb_word2", qa[2], 16'h0000);
        end
        chk("lb_rx_error", a_err, 0);
        loop = 1'b0;

        do_reset();
        b_m.tready = 1'b1;
        qb.delete();
        ser_b(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        chk("frm_rx_error", b_err, 1);
        chk("frm_no_data", qb.size(), 0);
        ser_b(8'h5A, 1'b1);
        repeat (40) @(negedge clk);
        chk("frm_next_count", qb.size(), 1);
        if (qb.size() == 1) chk("frm_next_data", qb[0], 8'h5A);

        do_reset();
        b_m.tready = 1'b0;
        qb.delete();
        ser_b(8'h11, 1'b1);
        repeat (20) @(negedge clk);
        chk("ovr_first_valid", b_m.tvalid, 1);
        chk("ovr_first_data", b_m.tdata, 8'h11);
        chk("ovr_first_err", b_err, 0);
        ser_b(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        chk("ovr_held_data", b_m.tdata, 8'h11);
        chk("ovr_held_valid", b_m.tvalid, 1);
        chk("ovr_rx_error", b_err, 1);
        b_m.tready = 1'b1;
        @(posedge clk);
        #1 b_m.tready = 1'b0;
        @(negedge clk);
        chk("ovr_valid_cleared", b_m.tvalid, 0);
        chk("ovr_taken_count", qb.size(), 1);

        do_reset();
        qb.delete();
        b_rxd = 1'b0;
        repeat (4) @(negedge clk);
        b_rxd = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (b_rxb) seen = 1'b1;
        end
        chk("fs_busy_seen", seen, 1);
        chk("fs_busy_end", b_rxb, 0);
        chk("fs_rx_error", b_err, 0);
        chk("fs_no_data", b_m.tvalid, 0);

        send_a(16'h0000, "mr");
        repeat (40) @(negedge clk);
        chk("mr_txd_before", a_txd, 0);
        chk("mr_busy_before", a_txb, 1);
        #2 arstn = 1'b0;
        #1;
        chk("mr_txd_in_reset", a_txd, 1);
        chk("mr_busy_in_reset", a_txb, 0);
        chk("mr_ready_in_reset", a_s.tready, 1);
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        // 3C then 96 after the abandoned frame
        tx_check(16'h3C96, 20'hCB278, "tx_3c96");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
